sos_window_norm: RTL

- Sits directly downstream of the 3x3 sum-of-squares window cache in the HOG block-normalisation path.
- On each window_valid it sums the nine cell sum-of-squares values into one block energy. It then computes the integer square root (the L2-norm denominator) with an iterative one-bit-per-cycle engine.
- Results are delivered on a valid/ready output together with the window index.
- A small input FIFO decouples window arrival from the serial root engine.

---
 rtl/sos_norm_pkg.sv | 32 +++
 rtl/sos_window_norm_isqrt_iter.sv | 69 ++++++
 rtl/sos_window_norm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sos_norm_pkg.sv
// ============================================================================
// Module  : sos_norm_pkg
// Brief   : Shared widths, FSM encoding and FIFO entry type for sos_window_norm.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sos_norm_pkg;

  localparam int TOTAL_BIT_WIDTH = 35;
  localparam int SUM_WIDTH       = TOTAL_BIT_WIDTH + 4;
  localparam int ROOT_WIDTH      = (SUM_WIDTH + 1) / 2;
  localparam int PART_WIDTH      = TOTAL_BIT_WIDTH + 2;
  localparam int IDX_WIDTH       = 10;

  // Added to the block energy only when SOS_NORM_EPS_EN is defined.
  localparam logic [SUM_WIDTH-1:0] EPS = SUM_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [SUM_WIDTH-1:0] sum;
    logic [IDX_WIDTH-1:0] idx;
  } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/sos_window_norm_isqrt_iter.sv
// ============================================================================
// Module  : isqrt_iter
// Brief   : Serial integer square root, one result bit per clock (restoring).
// Revision: 1.0
// ============================================================================
`default_nettype none

module isqrt_iter
  import sos_norm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SUM_WIDTH-1:0]  radicand,
  output logic                  busy,
  output logic                  done,
  output logic [ROOT_WIDTH-1:0] root
);

  localparam int PAD_WIDTH = 2 * ROOT_WIDTH;
  localparam int REM_WIDTH = ROOT_WIDTH + 2;
  localparam int CNT_WIDTH = $clog2(ROOT_WIDTH);

  logic [PAD_WIDTH-1:0] rad;
  logic [REM_WIDTH-1:0] rem;
  logic [CNT_WIDTH-1:0] iter;
  logic [REM_WIDTH-1:0] rem_shift;
  logic [REM_WIDTH-1:0] trial;
  logic [REM_WIDTH-1:0] rem_sub;
  logic                 take;

  // Remainder never exceeds 2*root, so ROOT_WIDTH+2 bits hold the shifted value.
  always_comb begin
    rem_shift = (rem << 2) | {{(REM_WIDTH-2){1'b0}}, rad[PAD_WIDTH-1 -: 2]};
    trial     = {root, 2'b01};
    take      = (rem_shift >= trial);
    rem_sub   = rem_shift - trial;
  end

  assign done = busy && (iter == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      rad  <= '0;
      rem  <= '0;
      iter <= '0;
      root <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rad  <= PAD_WIDTH'(radicand);
      rem  <= '0;
      root <= '0;
      iter <= CNT_WIDTH'(ROOT_WIDTH - 1);
    end else if (busy) begin
      rad  <= rad << 2;
      rem  <= take ? rem_sub : rem_shift;
      root <= {root[ROOT_WIDTH-2:0], take};
      if (iter == '0) begin
        busy <= 1'b0;
      end else begin
        iter <= iter - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sos_window_norm.sv
// ============================================================================
// Module  : sos_window_norm
// Brief   : 3x3 sum-of-squares block energy and its integer square root for HOG
//           normalisation. Optional macro SOS_NORM_EPS_EN adds EPS to the sum.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sos_window_norm
  import sos_norm_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int WIN_PER_FRAME = 1024
) (
  input  logic                       aclk,
  input  logic                       arest,
  input  logic                       window_valid,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg1,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg2,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg3,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg4,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg5,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg6,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg7,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg8,
  input  logic [TOTAL_BIT_WIDTH-1:0] sos_reg9,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROOT_WIDTH-1:0]      norm_root,
  output logic [SUM_WIDTH-1:0]       norm_sum,
  output logic [IDX_WIDTH-1:0]       win_idx,
  output logic                       fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Input capture, two-stage adder tree
  logic                       in_valid;
  logic [TOTAL_BIT_WIDTH-1:0] in_r [9];
  logic                       s1_valid;
  logic [PART_WIDTH-1:0]      p0, p1, p2;
  logic                       s2_valid;
  logic [SUM_WIDTH-1:0]       s2_sum;
  logic [SUM_WIDTH-1:0]       sum_raw;
  logic [SUM_WIDTH-1:0]       sum_next;

  // FIFO
  fifo_entry_t                mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [AW:0]                count;
  logic                       fifo_empty, fifo_full;
  logic                       push_ok, pop;
  logic [IDX_WIDTH-1:0]       win_cnt;
  fifo_entry_t                head;

  // Control / engine
  state_t                     state, state_next;
  logic                       start;
  logic                       eng_busy, eng_done;
  logic [SUM_WIDTH-1:0]       cur_sum;
  logic [IDX_WIDTH-1:0]       cur_idx;

  always_ff @(posedge aclk) begin
    if (arest) begin
      in_valid <= 1'b0;
      for (int i = 0; i < 9; i++) in_r[i] <= '0;
    end else begin
      in_valid <= window_valid;
      if (window_valid) begin
        in_r[0] <= sos_reg1; in_r[1] <= sos_reg2; in_r[2] <= sos_reg3;
        in_r[3] <= sos_reg4; in_r[4] <= sos_reg5; in_r[5] <= sos_reg6;
        in_r[6] <= sos_reg7; in_r[7] <= sos_reg8; in_r[8] <= sos_reg9;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      s1_valid <= 1'b0;
      p0       <= '0;
      p1       <= '0;
      p2       <= '0;
    end else begin
      s1_valid <= in_valid;
      p0 <= PART_WIDTH'(in_r[0]) + PART_WIDTH'(in_r[1]) + PART_WIDTH'(in_r[2]);
      p1 <= PART_WIDTH'(in_r[3]) + PART_WIDTH'(in_r[4]) + PART_WIDTH'(in_r[5]);
      p2 <= PART_WIDTH'(in_r[6]) + PART_WIDTH'(in_r[7]) + PART_WIDTH'(in_r[8]);
    end
  end

  always_comb begin
    sum_raw = SUM_WIDTH'(p0) + SUM_WIDTH'(p1) + SUM_WIDTH'(p2);
`ifdef SOS_NORM_EPS_EN
    sum_next = sum_raw + EPS;
`else
    sum_next = sum_raw;
`endif
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sum   <= sum_next;
    end
  end

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign push_ok    = s2_valid && (!fifo_full || pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{sum: s2_sum, idx: win_cnt};
    end
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      win_cnt       <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s2_valid) begin
        // Dropped windows still consume an index to keep frame alignment.
        win_cnt <= (win_cnt == IDX_WIDTH'(WIN_PER_FRAME - 1)) ? '0 : win_cnt + 1'b1;
        if (!push_ok) fifo_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      state   <= IDLE;
      cur_sum <= '0;
      cur_idx <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        cur_sum <= head.sum;
        cur_idx <= head.idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    pop        = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !eng_busy) begin
          pop        = 1'b1;
          start      = 1'b1;
          state_next = ITER;
        end
      end
      ITER: begin
        if (eng_done) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  isqrt_iter u_isqrt (
    .clk      (aclk),
    .rst      (arest),
    .start    (start),
    .radicand (head.sum),
    .busy     (eng_busy),
    .done     (eng_done),
    .root     (norm_root)
  );

  assign norm_sum = cur_sum;
  assign win_idx  = cur_idx;

endmodule

`default_nettype wire
